// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with phase FSMs, registered
// sync, video-active, coordinates and line/frame pulses, all aligned to one position.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       vga_clk,
  input  logic       RST,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int CW        = ($clog2(MAX_TOTAL) > 10) ? $clog2(MAX_TOTAL) : 10;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  // Counters and phases hold the position that the next edge will present.
  logic [CW-1:0] r_h_cnt, r_v_cnt;
  logic [1:0]    r_hph, r_vph;
  logic [CW-1:0] w_h_next, w_v_next;
  logic [1:0]    w_hph_next, w_vph_next;
  logic          w_h_wrap, w_v_wrap;

  always_comb begin
    w_h_wrap = (r_h_cnt == CW'(H_TOTAL - 1));
    w_v_wrap = (r_v_cnt == CW'(V_TOTAL - 1));
    w_h_next = w_h_wrap ? '0 : r_h_cnt + CW'(1);
    w_v_next = r_v_cnt;
    if (w_h_wrap) w_v_next = w_v_wrap ? '0 : r_v_cnt + CW'(1);
  end

  always_comb begin
    w_hph_next = r_hph;
    case (r_hph)
      ST_ACTIVE: if (w_h_next == CW'(H_ACTIVE))               w_hph_next = ST_FRONT;
      ST_FRONT:  if (w_h_next == CW'(H_ACTIVE + H_FP))        w_hph_next = ST_SYNC;
      ST_SYNC:   if (w_h_next == CW'(H_ACTIVE + H_FP + H_SYNC)) w_hph_next = ST_BACK;
      ST_BACK:   if (w_h_next == '0)                          w_hph_next = ST_ACTIVE;
    endcase
  end

  // Vertical phase only moves on the line wrap, so sync spans whole lines.
  always_comb begin
    w_vph_next = r_vph;
    if (w_h_wrap) begin
      case (r_vph)
        ST_ACTIVE: if (w_v_next == CW'(V_ACTIVE))               w_vph_next = ST_FRONT;
        ST_FRONT:  if (w_v_next == CW'(V_ACTIVE + V_FP))        w_vph_next = ST_SYNC;
        ST_SYNC:   if (w_v_next == CW'(V_ACTIVE + V_FP + V_SYNC)) w_vph_next = ST_BACK;
        ST_BACK:   if (w_v_next == '0)                          w_vph_next = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (RST) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_hph       <= ST_ACTIVE;
      r_vph       <= ST_ACTIVE;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      xPos        <= '0;
      yPos        <= '0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_h_cnt     <= w_h_next;
      r_v_cnt     <= w_v_next;
      r_hph       <= w_hph_next;
      r_vph       <= w_vph_next;
      hsync       <= (r_hph == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (r_vph == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (r_hph == ST_ACTIVE) && (r_vph == ST_ACTIVE);
      xPos        <= (r_hph == ST_ACTIVE) ? r_h_cnt[9:0] : 10'd0;
      yPos        <= (r_vph == ST_ACTIVE) ? r_v_cnt[9:0] : 10'd0;
      line_end    <= w_h_wrap;
      frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

endmodule
